formal_result_checker: RTL and testbench

FORMAL_RESULT_CHECKER -- requirements
Module: formal_result_checker

---
 rtl/formal_checker_pkg.sv | 14 +
 rtl/formal_result_checker_sat_counter.sv | 28 ++
 rtl/formal_result_checker.sv | 124 ++++++++++++
 tb/tb_formal_result_checker.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/formal_checker_pkg.sv
// Shared definitions for the formal result checker: FSM state encoding and
// the default number of compared samples per run.
package formal_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int RUN_SAMPLES_DEF = 400;

endpackage : formal_checker_pkg

// File: rtl/formal_result_checker_sat_counter.sv
// Saturating up-counter with increment enable and synchronous clear.
// It sticks at all-ones instead of wrapping back to zero.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule : sat_counter

// File: rtl/formal_result_checker.sv
// Compares FPGA fabric output against a golden bench output over one run.
// First-error capture is present only when FORMAL_CHECKER_FIRST_ERR_EN is defined.
module formal_result_checker
  import formal_checker_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int CNT_W       = 16,
  parameter int RUN_SAMPLES = RUN_SAMPLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] gfpga_out,
  input  logic [WIDTH-1:0] bench_out,
  output logic             mismatch_flag,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] first_err_cycle,
  output logic [WIDTH-1:0] first_err_mask,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  // Sample index is sized for the run length, independent of the error counter width.
  localparam int SC_W = $clog2(RUN_SAMPLES + 1);
  localparam logic [SC_W-1:0] LAST_IDX = SC_W'(RUN_SAMPLES - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [SC_W-1:0]   r_sample_cnt;
  logic              r_mismatch_flag;
  logic              r_busy;
  logic              r_done;
  logic              w_clear;
  logic              w_cmp;
  logic [WIDTH-1:0]  w_xor;
  logic              w_mism;
  logic              w_inc;

  assign w_xor  = gfpga_out ^ bench_out;
  assign w_mism = |w_xor;
  assign w_cmp  = (r_state == RUN) && sample_valid;
  // A run of consecutive mismatches is one episode.
  assign w_inc  = w_cmp && w_mism && !r_mismatch_flag;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next = WARMUP;
          w_clear      = 1'b1;
        end
      end
      WARMUP: begin
        if (sample_valid) w_state_next = RUN;
      end
      RUN: begin
        if (sample_valid && (r_sample_cnt == LAST_IDX)) w_state_next = DONE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_sample_cnt    <= '0;
      r_mismatch_flag <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == WARMUP) || (w_state_next == RUN);
      r_done  <= (w_state_next == DONE);
      if (w_clear) begin
        r_sample_cnt    <= '0;
        r_mismatch_flag <= 1'b0;
      end else if (w_cmp) begin
        r_sample_cnt    <= r_sample_cnt + SC_W'(1);
        r_mismatch_flag <= w_mism;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clear),
    .i_inc (w_inc),
    .o_cnt (error_count)
  );

`ifdef FORMAL_CHECKER_FIRST_ERR_EN
  logic [CNT_W-1:0] r_first_err_cycle;
  logic [WIDTH-1:0] r_first_err_mask;

  // The first mismatch of a run is exactly the one seen while error_count is still zero.
  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_first_err_cycle <= '0;
      r_first_err_mask  <= '0;
    end else if (w_cmp && w_mism && (error_count == '0)) begin
      r_first_err_cycle <= CNT_W'(r_sample_cnt);
      r_first_err_mask  <= w_xor;
    end
  end

  assign first_err_cycle = r_first_err_cycle;
  assign first_err_mask  = r_first_err_mask;
`else
  assign first_err_cycle = '0;
  assign first_err_mask  = '0;
`endif

  assign mismatch_flag = r_mismatch_flag;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = (r_state == DONE) && (error_count == '0);

endmodule : formal_result_checker

// File: tb/tb_formal_result_checker.sv
// Self-checking bench: three checker instances share stimulus and are compared
// against a sample-history reference model.
module tb_formal_result_checker;

`ifdef FORMAL_CHECKER_FIRST_ERR_EN
  localparam bit FIRST_EN = 1'b1;
`else
  localparam bit FIRST_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, sample_valid;
  logic [3:0] g4, b4;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // Instance a: WIDTH=1, RUN_SAMPLES=8
  logic a_flag, a_busy, a_done, a_pass;
  logic [15:0] a_err, a_fec;
  logic [0:0]  a_mask;
  formal_result_checker #(.WIDTH(1), .CNT_W(16), .RUN_SAMPLES(8)) u_a (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .gfpga_out(g4[0:0]), .bench_out(b4[0:0]), .mismatch_flag(a_flag),
    .error_count(a_err), .first_err_cycle(a_fec), .first_err_mask(a_mask),
    .busy(a_busy), .done(a_done), .pass(a_pass));

  // Instance s: WIDTH=1, CNT_W=2, RUN_SAMPLES=10 (saturation)
  logic s_flag, s_busy, s_done, s_pass;
  logic [1:0]  s_err, s_fec;
  logic [0:0]  s_mask;
  formal_result_checker #(.WIDTH(1), .CNT_W(2), .RUN_SAMPLES(10)) u_s (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .gfpga_out(g4[0:0]), .bench_out(b4[0:0]), .mismatch_flag(s_flag),
    .error_count(s_err), .first_err_cycle(s_fec), .first_err_mask(s_mask),
    .busy(s_busy), .done(s_done), .pass(s_pass));

  // Instance w: WIDTH=4, RUN_SAMPLES=8
  logic w_flag, w_busy, w_done, w_pass;
  logic [15:0] w_err, w_fec;
  logic [3:0]  w_mask;
  formal_result_checker #(.WIDTH(4), .CNT_W(16), .RUN_SAMPLES(8)) u_w (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .gfpga_out(g4), .bench_out(b4), .mismatch_flag(w_flag),
    .error_count(w_err), .first_err_cycle(w_fec), .first_err_mask(w_mask),
    .busy(w_busy), .done(w_done), .pass(w_pass));

  // Reference model: phase per instance plus the XOR history of compared samples.
  int         rs   [3] = '{8, 10, 8};
  int         cw   [3] = '{16, 2, 16};
  logic [3:0] wm   [3] = '{4'h1, 4'h1, 4'hF};
  int         mst  [3];  // 0 idle, 1 warm-up, 2 run, 3 done
  int         nh   [3];
  logic [3:0] hist [3][16];

  function automatic logic [39:0] obs(int d);
    case (d)
      0:       return {a_busy, a_done, a_pass, a_flag, a_err, a_fec, 3'b000, a_mask};
      1:       return {s_busy, s_done, s_pass, s_flag, 14'd0, s_err, 14'd0, s_fec, 3'b000, s_mask};
      default: return {w_busy, w_done, w_pass, w_flag, w_err, w_fec, w_mask};
    endcase
  endfunction

  function automatic logic [39:0] exp_out(int d);
    int         e  = 0;
    int         fi = -1;
    int         emax;
    logic [3:0] fm = 4'h0;
    logic [15:0] fc = 16'h0;
    logic       fl, bz, dn, ps;
    for (int i = 0; i < nh[d]; i++) begin
      if (hist[d][i] != 4'h0) begin
        if (i == 0 || hist[d][i-1] == 4'h0) e++;
        if (fi < 0) begin
          fi = i;
          fm = hist[d][i];
        end
      end
    end
    emax = (1 << cw[d]) - 1;
    if (e > emax) e = emax;
    fl = (nh[d] > 0) && (hist[d][nh[d]-1] != 4'h0);
    if (FIRST_EN && fi >= 0) fc = 16'(fi) & 16'(emax);
    else fm = 4'h0;
    bz = (mst[d] == 1) || (mst[d] == 2);
    dn = (mst[d] == 3);
    ps = dn && (e == 0);
    return {bz, dn, ps, fl, 16'(e), fc, fm};
  endfunction

  task automatic model_step(bit rst, bit st, bit v, logic [3:0] g, logic [3:0] b);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        mst[d] = 0;
        nh[d]  = 0;
      end else begin
        case (mst[d])
          0, 3: if (st) begin mst[d] = 1; nh[d] = 0; end
          1:    if (v) mst[d] = 2;
          default: if (v) begin
            hist[d][nh[d]] = (g ^ b) & wm[d];
            nh[d]++;
            if (nh[d] == rs[d]) mst[d] = 3;
          end
        endcase
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, settle 1 time unit past it.
  task automatic cycle(bit rst, bit st, bit v, logic [3:0] g, logic [3:0] b);
    reset = rst; start = st; sample_valid = v; g4 = g; b4 = b;
    @(posedge clk);
    model_step(rst, st, v, g, b);
    #1;
    reset = 1'b0; start = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] r;
    cycle(1, 0, 0, 4'h0, 4'h0);
    cycle(1, 1, 1, 4'hF, 4'h0);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== 40'h0) begin
        errors++; $display("FAIL reset_zero dut%0d got %h exp %h", d, obs(d), 40'h0);
      end
    end
    // Valid mismatching samples without a start must not disturb anything.
    for (int k = 0; k < 5; k++) begin
      r = 4'($urandom);
      cycle(0, 0, 1, r, ~r);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== exp_out(d)) begin
        errors++; $display("FAIL idle_hold dut%0d got %h exp %h", d, obs(d), exp_out(d));
      end
    end
  endtask

  task automatic test_clean_run();
    logic [3:0] r;
    cycle(1, 0, 0, 4'h0, 4'h0);
    cycle(0, 1, 0, 4'h0, 4'h0);
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL clean_busy got %b exp 1", a_busy);
    end
    for (int k = 0; k < 9; k++) begin
      r = 4'($urandom);
      cycle(0, 0, 1, r, r);
      if (k == 7) begin
        checks++;
        if (a_done !== 1'b0) begin
          errors++; $display("FAIL clean_early_done got %b exp 0", a_done);
        end
      end
    end
    checks++;
    if ({a_done, a_pass, a_busy, a_err} !== {3'b110, 16'd0}) begin
      errors++; $display("FAIL clean_done got %b%b%b err %0d exp 110 err 0", a_done, a_pass, a_busy, a_err);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== exp_out(d)) begin
        errors++; $display("FAIL clean_model dut%0d got %h exp %h", d, obs(d), exp_out(d));
      end
    end
  endtask

  task automatic test_warmup_discard();
    cycle(1, 0, 0, 4'h0, 4'h0);
    cycle(0, 1, 0, 4'h0, 4'h0);
    cycle(0, 0, 1, 4'h1, 4'h0);
    checks++;
    if ({a_flag, a_err} !== 17'd0) begin
      errors++; $display("FAIL warmup_flag got flag %b err %0d exp 0 0", a_flag, a_err);
    end
    for (int k = 0; k < 8; k++) cycle(0, 0, 1, 4'h5, 4'h5);
    checks++;
    if ({a_done, a_pass, a_err} !== {2'b11, 16'd0}) begin
      errors++; $display("FAIL warmup_pass got done %b pass %b err %0d exp 1 1 0", a_done, a_pass, a_err);
    end
  endtask

  task automatic test_episodes();
    bit exp_f;
    cycle(1, 0, 0, 4'h0, 4'h0);
    cycle(0, 1, 0, 4'h0, 4'h0);
    cycle(0, 0, 1, 4'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      exp_f = (i == 2) || (i == 3) || (i == 4) || (i == 6);
      cycle(0, 0, 1, exp_f ? 4'h1 : 4'h0, 4'h0);
      checks++;
      if (a_flag !== exp_f) begin
        errors++; $display("FAIL episode_flag idx %0d got %b exp %b", i, a_flag, exp_f);
      end
      if (i == 3) begin
        cycle(0, 0, 0, 4'h0, 4'h0);
        checks++;
        if (a_flag !== 1'b1) begin
          errors++; $display("FAIL episode_hold got %b exp 1", a_flag);
        end
      end
    end
    checks++;
    if (a_err !== 16'd2 || a_fec !== (FIRST_EN ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL episode_count got err %0d first %0d exp 2 %0d", a_err, a_fec, FIRST_EN ? 2 : 0);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== exp_out(d)) begin
        errors++; $display("FAIL episode_model dut%0d got %h exp %h", d, obs(d), exp_out(d));
      end
    end
  endtask

  task automatic test_saturation();
    cycle(1, 0, 0, 4'h0, 4'h0);
    cycle(0, 1, 0, 4'h0, 4'h0);
    cycle(0, 0, 1, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, (i % 2 == 0) ? 4'h1 : 4'h0, 4'h0);
      checks++;
      if (obs(1) !== exp_out(1)) begin
        errors++; $display("FAIL sat_model idx %0d got %h exp %h", i, obs(1), exp_out(1));
      end
    end
    checks++;
    if ({s_done, s_pass, s_err} !== 4'b1011) begin
      errors++; $display("FAIL sat_final got done %b pass %b err %0d exp 1 0 3", s_done, s_pass, s_err);
    end
  endtask

  task automatic test_reset_mid_run();
    cycle(1, 0, 0, 4'h0, 4'h0);
    cycle(0, 1, 0, 4'h0, 4'h0);
    cycle(0, 0, 1, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 4'h1, 4'h0);
    cycle(1, 1, 1, 4'h1, 4'h0);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== 40'h0) begin
        errors++; $display("FAIL midrun_reset dut%0d got %h exp %h", d, obs(d), 40'h0);
      end
    end
    cycle(0, 1, 0, 4'h0, 4'h0);
    for (int k = 0; k < 9; k++) cycle(0, 0, 1, 4'hA, 4'hA);
    checks++;
    if ({a_done, a_pass, a_err} !== {2'b11, 16'd0}) begin
      errors++; $display("FAIL midrun_rerun got done %b pass %b err %0d exp 1 1 0", a_done, a_pass, a_err);
    end
  endtask

  task automatic test_mask();
    cycle(1, 0, 0, 4'h0, 4'h0);
    cycle(0, 1, 0, 4'h0, 4'h0);
    cycle(0, 0, 1, 4'h0, 4'h0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, (i == 1) ? 4'b0100 : 4'b0011, 4'b0011 & ((i == 1) ? 4'h0 : 4'hF));
    checks++;
    if (w_err !== 16'd1 || w_mask !== (FIRST_EN ? 4'b0100 : 4'b0000) || w_fec !== (FIRST_EN ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL mask_capture got err %0d mask %b first %0d exp 1 %b %0d",
                         w_err, w_mask, w_fec, FIRST_EN ? 4'b0100 : 4'b0000, FIRST_EN ? 1 : 0);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== exp_out(d)) begin
        errors++; $display("FAIL mask_model dut%0d got %h exp %h", d, obs(d), exp_out(d));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] g, b;
    bit rst, st, v;
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 99) < 8);
      v   = ($urandom_range(0, 99) < 75);
      g   = 4'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : g;
      cycle(rst, st, v, g, b);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs(d) !== exp_out(d)) begin
          errors++; $display("FAIL random cyc %0d dut%0d got %h exp %h", k, d, obs(d), exp_out(d));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sample_valid = 1'b0; g4 = 4'h0; b4 = 4'h0;
    for (int d = 0; d < 3; d++) begin
      mst[d] = 0;
      nh[d]  = 0;
    end
    test_reset();
    test_clean_run();
    test_warmup_discard();
    test_episodes();
    test_saturation();
    test_reset_mid_run();
    test_mask();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_formal_result_checker
